// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: grants one tagged result per cycle and
// registers it for broadcast. Define CDB_STATS_EN to add grant/conflict counters.
module cdb_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LABEL_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [N_REQ-1:0]         require,
    input  logic [N_REQ*DATA_W-1:0]  dataIn,
    input  logic [N_REQ*LABEL_W-1:0] labelIn,
    input  logic                     hold,
    output logic [N_REQ-1:0]         requireAC,
    output logic                     BCEN,
    output logic [LABEL_W-1:0]       BClabel,
    output logic [DATA_W-1:0]        BCdata,
    output logic                     protoErr
`ifdef CDB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]   grantCount,
    output logic [CNT_W-1:0]         conflictCnt
`endif
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   label_zero;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [PTR_W-1:0]   idx;

    logic               bcen_q, bcen_d;
    logic [LABEL_W-1:0] bc_label_q, bc_label_d;
    logic [DATA_W-1:0]  bc_data_q, bc_data_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               proto_err_q, proto_err_d;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            label_zero[i] = (labelIn[i*LABEL_W +: LABEL_W] == '0);
        end
        eligible = require & ~label_zero & {N_REQ{~hold}};
    end

    // First eligible requester found walking upward from ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign requireAC = nRST ? grant : '0;

    always_comb begin
        bcen_d      = grant_vld;
        bc_label_d  = bc_label_q;
        bc_data_d   = bc_data_q;
        ptr_d       = ptr_q;
        proto_err_d = proto_err_q | (|(require & label_zero));
        if (grant_vld) begin
            bc_label_d = labelIn[32'(grant_idx)*LABEL_W +: LABEL_W];
            bc_data_d  = dataIn[32'(grant_idx)*DATA_W +: DATA_W];
            ptr_d      = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            bcen_q      <= 1'b0;
            bc_label_q  <= '0;
            bc_data_q   <= '0;
            ptr_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            bcen_q      <= bcen_d;
            bc_label_q  <= bc_label_d;
            bc_data_q   <= bc_data_d;
            ptr_q       <= ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign BCEN     = bcen_q;
    assign BClabel  = bc_label_q;
    assign BCdata   = bc_data_q;
    assign protoErr = proto_err_q;

`ifdef CDB_STATS_EN
    logic [N_REQ-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_W-1:0]            conflict_cnt_q, conflict_cnt_d;
    int unsigned                 elig_cnt;

    always_comb begin
        elig_cnt = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            elig_cnt = elig_cnt + 32'(eligible[i]);
        end
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (grant_vld && (grant_cnt_q[grant_idx] != '1)) begin
            grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 1'b1;
        end
        if ((elig_cnt >= 2) && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grantCount  = grant_cnt_q;
    assign conflictCnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: single grant, round-robin order,
// pointer wrap, tag-0 error, hold, and asynchronous reset mid-cycle.
module tb_cdb_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LABEL_W = 4;
    localparam int unsigned CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     nRST;
    logic [N_REQ-1:0]         require;
    logic [N_REQ*DATA_W-1:0]  dataIn;
    logic [N_REQ*LABEL_W-1:0] labelIn;
    logic                     hold;
    logic [N_REQ-1:0]         requireAC;
    logic                     BCEN;
    logic [LABEL_W-1:0]       BClabel;
    logic [DATA_W-1:0]        BCdata;
    logic                     protoErr;
`ifdef CDB_STATS_EN
    logic [N_REQ*CNT_W-1:0]   grantCount;
    logic [CNT_W-1:0]         conflictCnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    cdb_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .LABEL_W (LABEL_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk       (clk),
        .nRST      (nRST),
        .require   (require),
        .dataIn    (dataIn),
        .labelIn   (labelIn),
        .hold      (hold),
        .requireAC (requireAC),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .protoErr  (protoErr)
`ifdef CDB_STATS_EN
        ,
        .grantCount  (grantCount),
        .conflictCnt (conflictCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [LABEL_W-1:0] lab,
                            input logic [DATA_W-1:0] dat);
        labelIn[i*LABEL_W +: LABEL_W] = lab;
        dataIn[i*DATA_W +: DATA_W]    = dat;
    endtask

    task automatic check_bc(input string tag, input logic en, input logic [LABEL_W-1:0] lab,
                            input logic [DATA_W-1:0] dat);
        check({tag, "_en"}, 64'(BCEN), 64'(en));
        check({tag, "_label"}, 64'(BClabel), 64'(lab));
        check({tag, "_data"}, 64'(BCdata), 64'(dat));
    endtask

    initial begin
        logic [N_REQ-1:0] exp_ac;

        // Reset with a valid request present: grant must stay suppressed.
        nRST    = 1'b0;
        hold    = 1'b0;
        require = 4'b0001;
        dataIn  = '0;
        labelIn = '0;
        set_slot(0, 4'd3, 32'h0000_00AA);
        #2;
        check("rst_ac", 64'(requireAC), 64'h0);
        tick();
        tick();
        check_bc("rst", 1'b0, '0, '0);
        check("rst_perr", 64'(protoErr), 64'h0);
        #3 nRST = 1'b1;

        // Single request: same-cycle grant, broadcast next cycle.
        #1;
        check("single_ac", 64'(requireAC), 64'b0001);
        tick();
        check_bc("single", 1'b1, 4'd3, 32'h0000_00AA);
        require = 4'b0000;
        #1;
        check("single_drop_ac", 64'(requireAC), 64'h0);
        tick();
        check_bc("single_idle", 1'b0, 4'd3, 32'h0000_00AA);

        // Grant to 3 alone (ptr=1 -> 3 is only eligible) brings ptr back to 0.
        set_slot(3, 4'd4, 32'h0000_0103);
        require = 4'b1000;
        #1;
        check("alone3_ac", 64'(requireAC), 64'b1000);
        tick();
        check_bc("alone3", 1'b1, 4'd4, 32'h0000_0103);

        // All four eligible for 8 cycles: strict rotation 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 4; i++) set_slot(i, LABEL_W'(i + 1), 32'h100 + 32'(i));
        require = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_ac = 4'b0001 << (c % 4);
            #1;
            check($sformatf("rr%0d_ac", c), 64'(requireAC), 64'(exp_ac));
            tick();
            check_bc($sformatf("rr%0d", c), 1'b1, LABEL_W'((c % 4) + 1),
                     32'h100 + 32'(c % 4));
        end
`ifdef CDB_STATS_EN
        check("stat_conf8", 64'(conflictCnt), 64'd8);
        check("stat_g0", 64'(grantCount[0*CNT_W +: CNT_W]), 64'd3);
        check("stat_g1", 64'(grantCount[1*CNT_W +: CNT_W]), 64'd2);
        check("stat_g2", 64'(grantCount[2*CNT_W +: CNT_W]), 64'd2);
        check("stat_g3", 64'(grantCount[3*CNT_W +: CNT_W]), 64'd3);
`endif

        // Grant to 2 leaves ptr=3; then 0101 must wrap to 0 before 2.
        set_slot(2, 4'd5, 32'h0000_0205);
        require = 4'b0100;
        #1;
        check("g2_ac", 64'(requireAC), 64'b0100);
        tick();
        check_bc("g2", 1'b1, 4'd5, 32'h0000_0205);
        set_slot(0, 4'd6, 32'h0000_0006);
        set_slot(2, 4'd7, 32'h0000_0207);
        require = 4'b0101;
        #1;
        check("wrap_ac0", 64'(requireAC), 64'b0001);
        tick();
        check_bc("wrap0", 1'b1, 4'd6, 32'h0000_0006);
        require = 4'b0100;
        #1;
        check("wrap_ac2", 64'(requireAC), 64'b0100);
        tick();
        check_bc("wrap2", 1'b1, 4'd7, 32'h0000_0207);

        // Tag-0 request: never granted, sticky protocol error.
        set_slot(1, 4'd0, 32'hDEAD_0001);
        require = 4'b0010;
        #1;
        check("tag0_ac", 64'(requireAC), 64'h0);
        check("tag0_perr_pre", 64'(protoErr), 64'h0);
        tick();
        check("tag0_en", 64'(BCEN), 64'h0);
        check("tag0_perr", 64'(protoErr), 64'h1);
        require = 4'b0000;
        tick();
        check("tag0_perr_sticky", 64'(protoErr), 64'h1);

        // Hold for 3 cycles, then release: broadcast one cycle after hold falls.
        set_slot(3, 4'd9, 32'h0000_0099);
        require = 4'b1000;
        hold    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d_ac", c), 64'(requireAC), 64'h0);
            tick();
            check($sformatf("hold%0d_en", c), 64'(BCEN), 64'h0);
        end
        hold = 1'b0;
        #1;
        check("unhold_ac", 64'(requireAC), 64'b1000);
        tick();
        check_bc("unhold", 1'b1, 4'd9, 32'h0000_0099);
        // Sole eligible requester may be granted back to back.
        set_slot(3, 4'd10, 32'h0000_009A);
        #1;
        check("b2b_ac", 64'(requireAC), 64'b1000);
        tick();
        check_bc("b2b", 1'b1, 4'd10, 32'h0000_009A);

        // Move ptr to 2, then reset asynchronously while BCEN=1.
        set_slot(1, 4'd4, 32'h0000_0114);
        require = 4'b0010;
        tick();
        check_bc("pre_rst", 1'b1, 4'd4, 32'h0000_0114);
        #2 nRST = 1'b0;
        #1;
        check_bc("async_rst", 1'b0, '0, '0);
        check("async_rst_ac", 64'(requireAC), 64'h0);
        check("async_rst_perr", 64'(protoErr), 64'h0);
        #2 nRST = 1'b1;
        set_slot(1, 4'd4, 32'h0000_0124);
        set_slot(2, 4'd5, 32'h0000_0225);
        require = 4'b0110;
        #1;
        check("post_rst_ac", 64'(requireAC), 64'b0010);
        tick();
        check_bc("post_rst", 1'b1, 4'd4, 32'h0000_0124);
`ifdef CDB_STATS_EN
        check("stat_post_rst_g1", 64'(grantCount[1*CNT_W +: CNT_W]), 64'd1);
        check("stat_post_rst_conf", 64'(conflictCnt), 64'd1);
`endif
        require = 4'b0000;
        tick();
        check("final_idle_en", 64'(BCEN), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
